au_issue: RTL

AU_ISSUE -- requirements
Module: au_issue

---
 rtl/au_issue.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/au_issue.sv
// Micro-op issue stage for the arithmetic unit: a 4-deep op FIFO, an NREG x W
// register file, and an IDLE/ISSUE/WAIT/WB sequencer with a done timeout.
module au_issue #(
  parameter int W    = 24,
  parameter int NREG = 8,
  parameter int TMO  = 63
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         op_valid,
  output logic         op_ready,
  input  logic [1:0]   op_code,
  input  logic [1:0]   op_muly,
  input  logic [2:0]   op_ra,
  input  logic [2:0]   op_rb,
  input  logic [2:0]   op_rd,
  input  logic [W-1:0] op_imm,
  input  logic         wr_en,
  input  logic [2:0]   wr_addr,
  input  logic [W-1:0] wr_data,
  input  logic [2:0]   rd_addr,
  output logic [W-1:0] rd_data,
  output logic         au_start,
  output logic [W-1:0] au_R,
  output logic [W-1:0] au_S,
  output logic [W-1:0] au_Iimm,
  output logic [1:0]   au_op_sel,
  output logic [1:0]   au_mul_y_sel,
  input  logic [W-1:0] au_result,
  input  logic         au_done,
  output logic         idle,
  output logic         err_tmo
);
  localparam int CW = $clog2(TMO + 1);

  typedef struct packed {
    logic [1:0]   code;
    logic [1:0]   muly;
    logic [2:0]   ra;
    logic [2:0]   rb;
    logic [2:0]   rd;
    logic [W-1:0] imm;
  } uop_t;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} st_t;

  st_t            state, state_nxt;
  uop_t           fifo [4];
  logic [1:0]     wp, rp;
  logic [2:0]     cnt;
  logic [W-1:0]   rf [NREG];
  logic [2:0]     rd_q;
  logic [W-1:0]   res_q;
  logic [CW-1:0]  wcnt;
  logic           push, pop, tmo_hit;

  assign op_ready = (cnt != 3'd4);
  assign push     = op_valid && op_ready;
  assign pop      = (state == IDLE) && (cnt != 3'd0);
  assign tmo_hit  = (state == WAIT) && !au_done && (wcnt == CW'(TMO - 1));
  assign rd_data  = rf[rd_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
      for (int i = 0; i < 4; i++) fifo[i] <= '0;
    end else begin
      if (push) begin
        fifo[wp] <= '{code: op_code, muly: op_muly, ra: op_ra, rb: op_rb, rd: op_rd, imm: op_imm};
        wp       <= wp + 2'd1;
      end
      if (pop) rp <= rp + 2'd1;
      if (push && !pop)      cnt <= cnt + 3'd1;
      else if (pop && !push) cnt <= cnt - 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (cnt != 3'd0) state_nxt = ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT:  if (au_done) state_nxt = WB;
             else if (tmo_hit) state_nxt = IDLE;
      WB:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    au_start = (state == ISSUE);
    idle     = (state == IDLE) && (cnt == 3'd0);
  end

  // Operands are sampled from the file on the pop edge, so a host write on
  // that same edge is not seen by this op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      au_R         <= '0;
      au_S         <= '0;
      au_Iimm      <= '0;
      au_op_sel    <= '0;
      au_mul_y_sel <= '0;
      rd_q         <= '0;
      res_q        <= '0;
      wcnt         <= '0;
      err_tmo      <= 1'b0;
    end else begin
      if (pop) begin
        au_R         <= rf[fifo[rp].ra];
        au_S         <= rf[fifo[rp].rb];
        au_Iimm      <= fifo[rp].imm;
        au_op_sel    <= fifo[rp].code;
        au_mul_y_sel <= fifo[rp].muly;
        rd_q         <= fifo[rp].rd;
      end
      if (state == ISSUE) wcnt <= '0;
      else if (state == WAIT) wcnt <= wcnt + 1'b1;
      if (state == WAIT && au_done) res_q <= au_result;
      if (tmo_hit) err_tmo <= 1'b1;
    end
  end

  // r0 is never written; the writeback takes priority over the host port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (state == WB && rd_q == 3'(i))    rf[i] <= res_q;
        else if (wr_en && wr_addr == 3'(i)) rf[i] <= wr_data;
      end
    end
  end
endmodule
